// File: rtl/uart_serial_engine.sv
// uart_serial_engine: 8N1 UART with a fractional baud generator, 8-deep
// TX/RX FIFOs and a local reset synchronizer (async assert, sync release).
module uart_serial_engine #(
    parameter int OVERSAMPLE  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [9:0] div_int,
    input  logic [3:0] div_frac,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_done,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rxfifo_ren_ext,
    output logic       rx_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= '1;
        else     rst_sync_q <= rst_sync_q << 1;
    end

    assign rst_int = rst_sync_q[SYNC_STAGES-1];

    // Baud ticks: period is reloaded from div_int plus the accumulator carry.
    logic [10:0] per_q, cnt_q;
    logic [3:0]  acc_q;
    logic [4:0]  acc_sum;
    logic        tick;

    assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac};
    assign tick    = (per_q != '0) && (cnt_q == per_q - 11'd1);

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            per_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (per_q == '0) begin
            per_q <= {1'b0, div_int};
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
            acc_q <= acc_sum[3:0];
            per_q <= (div_int == '0) ? '0 : {1'b0, div_int} + {10'd0, acc_sum[4]};
        end else begin
            cnt_q <= cnt_q + 11'd1;
        end
    end

    logic [7:0]    txf_mem [FIFO_DEPTH];
    logic [AW-1:0] txf_wp_q, txf_rp_q;
    logic [AW:0]   txf_cnt_q;
    logic          txf_push, txf_pop;

    state_e        tx_st_q;
    logic          tx_q, tx_done_q, tx_last;
    logic [CW-1:0] tx_tcnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;

    assign txf_push = tx_valid && (txf_cnt_q != FULL);
    assign tx_last  = (tx_tcnt_q == LAST);
    assign txf_pop  = tick && (txf_cnt_q != '0) &&
                      (tx_st_q == IDLE || (tx_st_q == STOP && tx_last));

    always_ff @(posedge clk) begin
        if (txf_push) txf_mem[txf_wp_q] <= tx_byte;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            txf_wp_q  <= '0;
            txf_rp_q  <= '0;
            txf_cnt_q <= '0;
        end else begin
            if (txf_push) txf_wp_q <= txf_wp_q + 1'b1;
            if (txf_pop)  txf_rp_q <= txf_rp_q + 1'b1;
            if (txf_push && !txf_pop)      txf_cnt_q <= txf_cnt_q + 1'b1;
            else if (!txf_push && txf_pop) txf_cnt_q <= txf_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            tx_st_q   <= IDLE;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            tx_tcnt_q <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            if (tick) begin
                unique case (tx_st_q)
                    IDLE: begin
                        if (txf_pop) begin
                            tx_sh_q   <= txf_mem[txf_rp_q];
                            tx_q      <= 1'b0;
                            tx_tcnt_q <= '0;
                            tx_st_q   <= START;
                        end
                    end
                    START: begin
                        if (tx_last) begin
                            tx_tcnt_q <= '0;
                            tx_bit_q  <= '0;
                            tx_q      <= tx_sh_q[0];
                            tx_sh_q   <= tx_sh_q >> 1;
                            tx_st_q   <= DATA;
                        end else begin
                            tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tx_last) begin
                            tx_tcnt_q <= '0;
                            if (tx_bit_q == 3'd7) begin
                                tx_q    <= 1'b1;
                                tx_st_q <= STOP;
                            end else begin
                                tx_bit_q <= tx_bit_q + 3'd1;
                                tx_q     <= tx_sh_q[0];
                                tx_sh_q  <= tx_sh_q >> 1;
                            end
                        end else begin
                            tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tx_last) begin
                            tx_done_q <= 1'b1;
                            tx_tcnt_q <= '0;
                            // Queued data chains straight into the next start bit.
                            if (txf_pop) begin
                                tx_sh_q <= txf_mem[txf_rp_q];
                                tx_q    <= 1'b0;
                                tx_st_q <= START;
                            end else begin
                                tx_st_q <= IDLE;
                            end
                        end else begin
                            tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        end
                    end
                    default: tx_st_q <= IDLE;
                endcase
            end
        end
    end

    assign tx      = tx_q;
    assign tx_done = tx_done_q;

    logic [7:0]    rxf_mem [FIFO_DEPTH];
    logic [AW-1:0] rxf_wp_q, rxf_rp_q;
    logic [AW:0]   rxf_cnt_q;
    logic          rxf_push, rxf_pop;

    state_e        rx_st_q;
    logic          rx_s1_q, rx_s_q, rx_prev_q, rx_valid_q, rx_last;
    logic [CW-1:0] rx_tcnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;

    assign rx_last  = (rx_tcnt_q == LAST);
    assign rxf_push = tick && (rx_st_q == STOP) && rx_last && rx_s_q &&
                      (rxf_cnt_q != FULL);
    assign rxf_pop  = rxfifo_ren_ext && (rxf_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rxf_push) rxf_mem[rxf_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            rxf_wp_q  <= '0;
            rxf_rp_q  <= '0;
            rxf_cnt_q <= '0;
        end else begin
            if (rxf_push) rxf_wp_q <= rxf_wp_q + 1'b1;
            if (rxf_pop)  rxf_rp_q <= rxf_rp_q + 1'b1;
            if (rxf_push && !rxf_pop)      rxf_cnt_q <= rxf_cnt_q + 1'b1;
            else if (!rxf_push && rxf_pop) rxf_cnt_q <= rxf_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            rx_s1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= IDLE;
            rx_valid_q <= 1'b0;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s_q     <= rx_s1_q;
            rx_prev_q  <= rx_s_q;
            rx_valid_q <= rxf_push;
            unique case (rx_st_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        rx_st_q   <= START;
                        rx_tcnt_q <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        // Mid start bit: a high line means it was only a glitch.
                        if (rx_tcnt_q == HALF) begin
                            if (rx_s_q) begin
                                rx_st_q <= IDLE;
                            end else begin
                                rx_st_q   <= DATA;
                                rx_tcnt_q <= '0;
                                rx_bit_q  <= '0;
                            end
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (rx_last) begin
                            rx_tcnt_q <= '0;
                            rx_sh_q   <= {rx_s_q, rx_sh_q[7:1]};
                            if (rx_bit_q == 3'd7) rx_st_q  <= STOP;
                            else                  rx_bit_q <= rx_bit_q + 3'd1;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_last) begin
                            rx_tcnt_q <= '0;
                            rx_st_q   <= IDLE;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        end
                    end
                end
                default: rx_st_q <= IDLE;
            endcase
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_irq   = (rxf_cnt_q != '0);
    assign rx_byte  = (rxf_cnt_q != '0) ? rxf_mem[rxf_rp_q] : 8'h00;

endmodule

// File: tb/tb_uart_serial_engine.sv
// Self-checking bench for uart_serial_engine: vector table, corner-case
// sequences and a randomized loopback against a byte-queue reference.
module tb_uart_serial_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_line;
    logic       tx;
    logic [9:0] div_int = 10'd4;
    logic [3:0] div_frac = 4'd0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_done;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rxfifo_ren_ext = 1'b0;
    logic       rx_irq;

    always #5 clk = ~clk;
    assign rx_line = loop ? tx : rx_drv;

    uart_serial_engine dut (
        .clk(clk), .rst(rst), .rx(rx_line), .tx(tx),
        .div_int(div_int), .div_frac(div_frac),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_done(tx_done),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rxfifo_ren_ext(rxfifo_ren_ext), .rx_irq(rx_irq)
    );

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rxv_cnt = 0;
    int checks = 0;
    int passed = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rx_valid === 1'b1) rxv_cnt++;
    end

    typedef struct {
        int         di;
        int         df;
        logic [7:0] data;
        int         len;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic get_frame(input real bl, output logic [9:0] bits,
                             output int fall, output logic ok);
        int n;
        n = 0;
        ok = 1'b1;
        bits = '0;
        fall = cyc;
        while (tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        fall = cyc;
        for (int k = 0; k < 10; k++) begin
            while (cyc < fall + int'(bl * (real'(k) + 0.5))) @(negedge clk);
            bits[k] = tx;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rxv(input int target, input int budget);
        int n;
        n = 0;
        while (rxv_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_byte  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, rx_byte, exp);
        rxfifo_ren_ext = 1'b1;
        @(negedge clk);
        rxfifo_ren_ext = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (16) @(negedge clk);
        end
        rx_drv = stopb;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    logic [9:0] bits;
    logic       ok;
    int         fall, prev_fall, d0, r0, n;
    logic [7:0] bq [$];
    logic [7:0] b;

    initial begin
        vt[0] = '{4, 0,  8'hA5, 160};
        vt[1] = '{4, 8,  8'h00, 180};
        vt[2] = '{5, 4,  8'h3C, 210};
        vt[3] = '{6, 12, 8'hC3, 270};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_irq", rx_irq, 0);
        chk("reset_rx_byte", rx_byte, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            div_int  = 10'(vt[i].di);
            div_frac = 4'(vt[i].df);
            repeat (20) @(negedge clk);
            d0 = done_cnt;
            push(vt[i].data);
            get_frame(4.0 * (real'(vt[i].di) + real'(vt[i].df) / 16.0), bits, fall, ok);
            chk($sformatf("vec%0d_started", i), ok, 1);
            chk($sformatf("vec%0d_bits", i), bits, frame_of(vt[i].data));
            wait_done(d0 + 1, 400);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_done_cnt", i), done_cnt - d0, 1);
            chk_rng($sformatf("vec%0d_len", i), done_cyc - fall, vt[i].len - 1, vt[i].len + 1);
        end

        // Back-to-back pushes must give contiguous frames.
        @(negedge clk);
        div_int  = 10'd4;
        div_frac = 4'd0;
        repeat (20) @(negedge clk);
        d0 = done_cnt;
        bq = '{8'h78, 8'h56, 8'h34, 8'h12};
        foreach (bq[i]) begin
            tx_byte  = bq[i];
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        prev_fall = 0;
        foreach (bq[i]) begin
            get_frame(16.0, bits, fall, ok);
            chk($sformatf("b2b%0d_bits", i), bits, frame_of(bq[i]));
            if (i > 0) chk($sformatf("b2b%0d_gap", i), fall - prev_fall, 160);
            prev_fall = fall;
        end
        wait_done(d0 + 4, 400);
        repeat (20) @(negedge clk);
        chk("b2b_done_cnt", done_cnt - d0, 4);

        // Frozen divider: TX FIFO fills to 8, then loopback fills RX FIFO.
        div_int = 10'd0;
        repeat (30) @(negedge clk);
        loop = 1'b1;
        d0 = done_cnt;
        r0 = rxv_cnt;
        bq = {};
        for (int i = 0; i < 10; i++) bq.push_back(8'(8'h90 + i));
        foreach (bq[i]) begin
            tx_byte  = bq[i];
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("frozen_tx_idle", tx, 1);
        div_int = 10'd4;
        wait_rxv(r0 + 8, 3000);
        chk("rxfull_count", rxv_cnt - r0, 8);
        chk("rxfull_irq", rx_irq, 1);
        push(8'hEE);
        wait_done(d0 + 9, 3000);
        repeat (40) @(negedge clk);
        chk("txfull_drop", done_cnt - d0, 9);
        chk("rxfull_no_valid", rxv_cnt - r0, 8);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("rxfull_pop%0d", i), bq[i]);
        chk("rx_empty_irq", rx_irq, 0);
        chk("rx_empty_byte", rx_byte, 0);
        rxfifo_ren_ext = 1'b1;
        @(negedge clk);
        rxfifo_ren_ext = 1'b0;
        @(negedge clk);
        chk("pop_empty_ignored", {rx_irq, rx_byte}, 0);

        // Framing error, glitch, then a clean frame on a hand-driven line.
        loop = 1'b0;
        r0 = rxv_cnt;
        send_rx(8'hC3, 1'b0);
        chk("frame_err_no_valid", rxv_cnt - r0, 0);
        chk("frame_err_irq", rx_irq, 0);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_no_valid", rxv_cnt - r0, 0);
        chk("glitch_irq", rx_irq, 0);
        send_rx(8'h5A, 1'b1);
        chk("good_rx_valid", rxv_cnt - r0, 1);
        chk("good_rx_byte", rx_byte, 8'h5A);
        chk("good_rx_irq", rx_irq, 1);

        // Reset mid-frame: immediate abort, FIFOs cleared, 2-edge release.
        d0 = done_cnt;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_frame_started", tx, 0);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_tx_immediate", tx, 1);
        chk("rst_rx_irq", rx_irq, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_done_valid", {tx_done, rx_valid}, 0);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        tx_byte  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_byte = 8'hBB;
        @(negedge clk);
        tx_valid = 1'b0;
        get_frame(16.0, bits, fall, ok);
        chk("rel_frame_started", ok, 1);
        chk("rel_frame_bits", bits, frame_of(8'hBB));
        repeat (300) @(negedge clk);
        chk("rel_one_frame", done_cnt - d0, 1);

        // Randomized loopback against a byte queue.
        loop = 1'b1;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            div_int  = 10'($urandom_range(4, 7));
            div_frac = 4'($urandom_range(0, 15));
            repeat (30) @(negedge clk);
            r0 = rxv_cnt;
            bq = {};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bq.push_back(b);
                push(b);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_rxv(r0 + n, n * 400 + 500);
            repeat (10) @(negedge clk);
            chk($sformatf("rnd%0d_count", r), rxv_cnt - r0, n);
            while (bq.size() > 0) pop_chk($sformatf("rnd%0d_byte", r), bq.pop_front());
            chk($sformatf("rnd%0d_irq", r), rx_irq, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
